// File: rtl/vga_bg_pixel.sv
// Background pixel generator: image ROM lookup, palette resolve and play-field grid overlay.
// Three-stage pipeline, one pixel per clock, all outputs aligned to the same pixel.
module vga_bg_pixel #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned GRID_TOP    = 80,
  parameter int unsigned GRID_BOTTOM = 400,
  parameter int unsigned GRID_LEFT   = 240,
  parameter int unsigned GRID_RIGHT  = 400,
  parameter int unsigned CELL        = 16,
  parameter logic [23:0] GRID_COLOR  = 24'h444444,
  parameter string       IMG_FILE    = "img_data.mif",
  parameter string       PAL_FILE    = "img_index.mif"
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [18:0] iADDR,
  output logic [23:0] oBGR,
  output logic        oEDGE,
  output logic [9:0]  oX,
  output logic [9:0]  oY
);

  localparam int unsigned ImgDepth = H_ACTIVE * V_ACTIVE;
  localparam logic [9:0]  CellMask = 10'(CELL - 1);

  logic [7:0]  img_rom [ImgDepth];
  logic [23:0] pal_rom [256];

  // Stage 0: address translation and grid decode
  logic [9:0] x_s, y_s, dx_s, dy_s;
  logic       in_field_s, on_line_s, edge_s, in_range_s;

  always_comb begin
    x_s        = 10'(iADDR / 19'(H_ACTIVE));
    y_s        = 10'(iADDR % 19'(H_ACTIVE));
    dx_s       = x_s - 10'(GRID_TOP);
    dy_s       = y_s - 10'(GRID_LEFT);
    in_field_s = (x_s >= 10'(GRID_TOP))  && (x_s <= 10'(GRID_BOTTOM)) &&
                 (y_s >= 10'(GRID_LEFT)) && (y_s <= 10'(GRID_RIGHT));
    on_line_s  = ((dx_s & CellMask) == '0) || ((dy_s & CellMask) == '0);
    edge_s     = in_field_s && on_line_s;
    in_range_s = iADDR < 19'(ImgDepth);
  end

  // Pipeline registers
  logic [7:0]  idx_q, idx_d;
  logic [23:0] pal_q, pal_d;
  logic [9:0]  x1_q, y1_q, x2_q, y2_q;
  logic        edge1_q, edge2_q;
  // Valid tokens keep the palette output of a reset index from leaking out after release.
  logic        vld1_q, vld2_q;
  logic [23:0] bgr_q, bgr_d;
  logic        edge3_q;
  logic [9:0]  x3_q, y3_q;

  always_comb begin
    idx_d = '0;
    if (in_range_s) begin
      idx_d = img_rom[iADDR];
    end
    pal_d = pal_rom[idx_q];
    bgr_d = '0;
    if (vld2_q) begin
      bgr_d = edge2_q ? GRID_COLOR : pal_q;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      idx_q   <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      edge1_q <= 1'b0;
      vld1_q  <= 1'b0;
      pal_q   <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      edge2_q <= 1'b0;
      vld2_q  <= 1'b0;
      bgr_q   <= '0;
      edge3_q <= 1'b0;
      x3_q    <= '0;
      y3_q    <= '0;
    end else begin
      idx_q   <= idx_d;
      x1_q    <= x_s;
      y1_q    <= y_s;
      edge1_q <= edge_s;
      vld1_q  <= 1'b1;
      pal_q   <= pal_d;
      x2_q    <= x1_q;
      y2_q    <= y1_q;
      edge2_q <= edge1_q;
      vld2_q  <= vld1_q;
      bgr_q   <= bgr_d;
      edge3_q <= edge2_q & vld2_q;
      x3_q    <= vld2_q ? x2_q : '0;
      y3_q    <= vld2_q ? y2_q : '0;
    end
  end

  assign oBGR  = bgr_q;
  assign oEDGE = edge3_q;
  assign oX    = x3_q;
  assign oY    = y3_q;

endmodule

// File: tb/tb_vga_bg_pixel.sv
// Self-checking bench for vga_bg_pixel: ROMs preloaded with known patterns, table vectors,
// streaming runs and reset sequences checked through an expected-output queue.
module tb_vga_bg_pixel;

  logic        clk;
  logic        rst_n;
  logic [18:0] addr;
  logic [23:0] bgr;
  logic        edg;
  logic [9:0]  x, y;

  int checks = 0;
  int errors = 0;

  vga_bg_pixel #(
    .IMG_FILE(""),
    .PAL_FILE("")
  ) dut (
    .iVGA_CLK(clk),
    .iRST_n  (rst_n),
    .iADDR   (addr),
    .oBGR    (bgr),
    .oEDGE   (edg),
    .oX      (x),
    .oY      (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] bgr;
    logic        edg;
    logic [9:0]  x;
    logic [9:0]  y;
    bit          chk;
    string       nm;
  } exp_t;

  typedef struct {
    int unsigned addr;
    logic        edg;
    int unsigned x;
    int unsigned y;
    string       nm;
  } vec_t;

  exp_t exp_q[$];

  function automatic logic [7:0] img_f(int unsigned a);
    return 8'((a * 32'd2654435761) >> 13) ^ 8'(a);
  endfunction

  function automatic logic [23:0] pal_f(logic [7:0] i);
    return {i ^ 8'h5A, 8'(i * 3 + 1), ~i};
  endfunction

  function automatic logic [7:0] idx_f(int unsigned a);
    return (a < 307200) ? img_f(a) : 8'h00;
  endfunction

  function automatic exp_t model(int unsigned a, string nm);
    exp_t e;
    int unsigned mx, my;
    bit in_f;
    mx = a / 640;
    my = a % 640;
    in_f = (mx >= 80) && (mx <= 400) && (my >= 240) && (my <= 400);
    e.edg = in_f && ((((mx - 80) % 16) == 0) || (((my - 240) % 16) == 0));
    e.bgr = e.edg ? 24'h444444 : pal_f(idx_f(a));
    e.x   = 10'(mx);
    e.y   = 10'(my);
    e.chk = 1'b1;
    e.nm  = nm;
    return e;
  endfunction

  function automatic exp_t zero_exp(string nm);
    exp_t e;
    e.bgr = '0;
    e.edg = 1'b0;
    e.x   = '0;
    e.y   = '0;
    e.chk = 1'b1;
    e.nm  = nm;
    return e;
  endfunction

  task automatic check(string nm, logic [44:0] got, logic [44:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got bgr=%h edge=%b x=%0d y=%0d, expected bgr=%h edge=%b x=%0d y=%0d",
               nm, got[44:21], got[20], got[19:10], got[9:0],
               want[44:21], want[20], want[19:10], want[9:0]);
    end
  endtask

  // Drive one address; the output popped after this edge belongs to the address 3 steps back.
  task automatic step(input logic [18:0] a, input exp_t e);
    exp_t f;
    addr = a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() >= 3) begin
      f = exp_q.pop_front();
      if (f.chk) check(f.nm, {bgr, edg, x, y}, {f.bgr, f.edg, f.x, f.y});
    end
  endtask

  task automatic drain();
    exp_t d;
    d = zero_exp("drain");
    d.chk = 1'b0;
    repeat (3) step(19'd0, d);
  endtask

  vec_t vecs[12];

  initial begin
    exp_t e;
    vecs[0]  = '{addr: 0,      edg: 1'b0, x: 0,   y: 0,   nm: "addr0"};
    vecs[1]  = '{addr: 51500,  edg: 1'b1, x: 80,  y: 300, nm: "grid_top_row"};
    vecs[2]  = '{addr: 52081,  edg: 1'b0, x: 81,  y: 241, nm: "inside_cell"};
    vecs[3]  = '{addr: 256400, edg: 1'b1, x: 400, y: 400, nm: "bottom_right_corner"};
    vecs[4]  = '{addr: 257041, edg: 1'b0, x: 401, y: 401, nm: "past_bottom_right"};
    vecs[5]  = '{addr: 51439,  edg: 1'b0, x: 80,  y: 239, nm: "left_of_field"};
    vecs[6]  = '{addr: 52096,  edg: 1'b1, x: 81,  y: 256, nm: "grid_column"};
    vecs[7]  = '{addr: 50860,  edg: 1'b0, x: 79,  y: 300, nm: "above_field"};
    vecs[8]  = '{addr: 128401, edg: 1'b0, x: 200, y: 401, nm: "right_of_field"};
    vecs[9]  = '{addr: 256240, edg: 1'b1, x: 400, y: 240, nm: "bottom_left_corner"};
    vecs[10] = '{addr: 307199, edg: 1'b0, x: 479, y: 639, nm: "last_pixel"};
    vecs[11] = '{addr: 307200, edg: 1'b0, x: 480, y: 0,   nm: "out_of_range"};

    rst_n = 1'b1;
    addr  = '0;
    for (int i = 0; i < 307200; i++) dut.img_rom[i] = img_f(i);
    for (int i = 0; i < 256; i++) dut.pal_rom[i] = pal_f(8'(i));
    #2 rst_n = 1'b0;

    // Reset held with the clock running
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {bgr, edg, x, y}, '0);

    // Release; the first two edges after release still show zeros
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(zero_exp("post_release_edge1"));
    exp_q.push_back(zero_exp("post_release_edge2"));

    // Table vectors, applied back to back
    for (int i = 0; i < 12; i++) begin
      e = zero_exp(vecs[i].nm);
      e.edg = vecs[i].edg;
      e.x   = 10'(vecs[i].x);
      e.y   = 10'(vecs[i].y);
      e.bgr = vecs[i].edg ? 24'h444444 : pal_f(idx_f(vecs[i].addr));
      step(19'(vecs[i].addr), e);
    end
    drain();

    // Streaming from the top-left corner
    for (int a = 0; a < 2000; a++) step(19'(a), model(a, "stream_head"));

    // Asynchronous reset mid-stream, away from the clock edge
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_clear", {bgr, edg, x, y}, '0);
    exp_q.delete();
    #13 rst_n = 1'b1;
    exp_q.push_back(zero_exp("midrst_edge1"));
    exp_q.push_back(zero_exp("midrst_edge2"));

    // Streaming through the end of the frame and past it
    for (int a = 305200; a < 307203; a++) step(19'(a), model(a, "stream_tail"));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
